// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and a full-width two's-complement negate helper.
package mdu_pkg;

  localparam logic [1:0] MDU_MULU = 2'b00;
  localparam logic [1:0] MDU_MUL  = 2'b01;
  localparam logic [1:0] MDU_DIVU = 2'b10;
  localparam logic [1:0] MDU_DIV  = 2'b11;

  // Widest operand pair the negate helper covers (2 * max DATA_W).
  localparam int MDU_MAX_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  function automatic logic [MDU_MAX_W-1:0] mdu_neg(input logic [MDU_MAX_W-1:0] v);
    return ~v + MDU_MAX_W'(1);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module mdu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_bit,
  input  logic [DATA_W-1:0] i_dvsr,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_q
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_sub;

  assign w_shift = {i_rem, i_bit};
  assign o_q     = (w_shift >= {1'b0, i_dvsr});
  assign w_sub   = w_shift - {1'b0, i_dvsr};
  // Whichever branch is taken, the result is below the divisor and fits DATA_W.
  assign o_rem   = DATA_W'(o_q ? w_sub : w_shift);

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit, one bit per cycle, signed via magnitude + sign fix.
// Optional MDU_EARLY_OUT_EN: multiplies leave CALC once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start_i; operands latched on acceptance
// PREP  | take magnitudes, record result signs, trap divide-by-zero
// CALC  | DATA_W shift-add (mul) or restoring shift-subtract (div) steps
// FIX   | apply sign correction and load hi/lo
// DONE  | done_o pulse; results held
module mul_div_unit import mdu_pkg::*; #(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_zero_o
);

  localparam int ACC_W = 2 * DATA_W;

  mdu_state_e        r_state, w_state_nxt;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_src1, r_src2;
  logic [ACC_W-1:0]  r_acc, r_opa;
  logic [DATA_W-1:0] r_opb, r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_lo, r_neg_hi;
  logic [DATA_W-1:0] r_hi, r_lo;
  logic              r_dz;

  logic              w_is_div, w_signed, w_s1, w_s2, w_div_zero, w_step_q;
  logic [DATA_W-1:0] w_abs1, w_abs2, w_step_rem, w_quo_neg, w_rem_neg;
  logic [ACC_W-1:0]  w_acc_neg;

  assign w_is_div   = (r_mode == MDU_DIVU) || (r_mode == MDU_DIV);
  assign w_signed   = (r_mode == MDU_MUL)  || (r_mode == MDU_DIV);
  assign w_s1       = w_signed & r_src1[DATA_W-1];
  assign w_s2       = w_signed & r_src2[DATA_W-1];
  assign w_abs1     = w_s1 ? DATA_W'(mdu_neg(MDU_MAX_W'(r_src1))) : r_src1;
  assign w_abs2     = w_s2 ? DATA_W'(mdu_neg(MDU_MAX_W'(r_src2))) : r_src2;
  assign w_div_zero = w_is_div && (r_src2 == '0);
  assign w_acc_neg  = ACC_W'(mdu_neg(MDU_MAX_W'(r_acc)));
  assign w_quo_neg  = DATA_W'(mdu_neg(MDU_MAX_W'(r_opb)));
  assign w_rem_neg  = DATA_W'(mdu_neg(MDU_MAX_W'(r_rem)));

  // Divisor magnitude lives in the low half of r_opa; r_opb shifts dividend out / quotient in.
  mdu_div_step #(.DATA_W(DATA_W)) u_div_step (
    .i_rem  (r_rem),
    .i_bit  (r_opb[DATA_W-1]),
    .i_dvsr (r_opa[DATA_W-1:0]),
    .o_rem  (w_step_rem),
    .o_q    (w_step_q)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = ST_PREP;
      ST_PREP: begin
        if (w_div_zero) w_state_nxt = ST_DONE;
        else begin
          w_state_nxt = ST_CALC;
`ifdef MDU_EARLY_OUT_EN
          if (!w_is_div && (w_abs2 == '0)) w_state_nxt = ST_FIX;
`endif
        end
      end
      ST_CALC: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FIX;
`ifdef MDU_EARLY_OUT_EN
        if (!w_is_div && (r_opb[DATA_W-1:1] == '0)) w_state_nxt = ST_FIX;
`endif
      end
      ST_FIX:  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush_i) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (r_state)
      ST_PREP, ST_CALC, ST_FIX: busy_o = 1'b1;
      ST_DONE:                  done_o = 1'b1;
      default: ;
    endcase
  end

  // Flush freezes the datapath so the previous results stay visible.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mode   <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_acc    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dz     <= 1'b0;
    end else if (!flush_i) begin
      case (r_state)
        ST_IDLE: if (start_i) begin
          r_mode <= mode_i;
          r_src1 <= src1_i;
          r_src2 <= src2_i;
          r_dz   <= 1'b0;
        end
        ST_PREP: begin
          r_cnt    <= CNT_W'(DATA_W);
          r_acc    <= '0;
          r_rem    <= '0;
          r_neg_lo <= w_s1 ^ w_s2;
          if (w_is_div) begin
            r_opa    <= ACC_W'(w_abs2);
            r_opb    <= w_abs1;
            r_neg_hi <= w_s1;
          end else begin
            r_opa    <= ACC_W'(w_abs1);
            r_opb    <= w_abs2;
            r_neg_hi <= w_s1 ^ w_s2;
          end
          if (w_div_zero) begin
            r_hi <= r_src1;
            r_lo <= '1;
            r_dz <= 1'b1;
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_is_div) begin
            r_rem <= w_step_rem;
            r_opb <= {r_opb[DATA_W-2:0], w_step_q};
          end else begin
            if (r_opb[0]) r_acc <= r_acc + r_opa;
            r_opa <= r_opa << 1;
            r_opb <= r_opb >> 1;
          end
        end
        ST_FIX: begin
          if (w_is_div) begin
            r_lo <= r_neg_lo ? w_quo_neg : r_opb;
            r_hi <= r_neg_hi ? w_rem_neg : r_rem;
          end else begin
            {r_hi, r_lo} <= r_neg_lo ? w_acc_neg : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign div_zero_o = r_dz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (DATA_W=32): directed ops push expected
// results; a monitor pops and checks on every done_o pulse.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'b00;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] hi_o, lo_o;

  mul_div_unit #(.DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i), .busy_o(busy_o),
    .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o), .div_zero_o(div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          t0;
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  exp_t  m_e;
  string m_nm;
  int    m_lat;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int mul_lat(input logic [31:0] b_abs);
`ifdef MDU_EARLY_OUT_EN
    int m = -1;
    for (int i = 0; i < 32; i++) if (b_abs[i]) m = i;
    return (m < 0) ? 3 : 3 + m + 1;
`else
    return (b_abs == 32'hFFFF_FFFF) ? 35 : 35;
`endif
  endfunction

  // Monitor: every done_o pulse must match the oldest outstanding op.
  always @(posedge clk_i) begin
    #1;
    if (rst_i && done_o) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done_o=1 expected no pending op");
      end else begin
        m_e   = sb.pop_front();
        m_nm  = sb_nm.pop_front();
        m_lat = cyc - m_e.t0 + 1;
        chk({m_nm, "_hi"},  64'(hi_o), 64'(m_e.hi));
        chk({m_nm, "_lo"},  64'(lo_o), 64'(m_e.lo));
        chk({m_nm, "_dz"},  64'(div_zero_o), 64'(m_e.dz));
        chk({m_nm, "_lat"}, 64'(m_lat), 64'(m_e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                       output int t0);
    int k = 0;
    @(negedge clk_i);
    while ((busy_o || done_o) && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_wait: got busy/done still high expected idle within 200 cycles");
    end
    mode_i  = md;
    src1_i  = a;
    src2_i  = b;
    start_i = 1'b1;
    t0 = cyc + 1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int busy_n);
    int k = 0;
    busy_n = 0;
    while (!done_o && k < 200) begin
      if (busy_o) busy_n++;
      @(posedge clk_i);
      #1;
      k++;
    end
    if (!done_o) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done_o expected done within 200 cycles", nm);
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] md, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat, output int busy_n);
    exp_t e;
    int   t0;
    issue(md, a, b, t0);
    chk({nm, "_dzclr"}, 64'(div_zero_o), 64'(0));
    e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat; e.t0 = t0;
    sb.push_back(e);
    sb_nm.push_back(nm);
    wait_done(nm, busy_n);
  endtask

  initial begin
    int bn, t0, quiet;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_hi",   64'(hi_o),   64'(0));
    chk("rst_lo",   64'(lo_o),   64'(0));
    chk("rst_dz",   64'(div_zero_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;

    run_op("mulu_max", MDU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, bn);
    chk("mulu_max_busy", 64'(bn), 64'(34));
    run_op("mul_neg",  MDU_MUL,  32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, mul_lat(32'd3), bn);
    run_op("div_neg",  MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, bn);
    run_op("divu_z",   MDU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 2, bn);
    run_op("divu_7",   MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35, bn);
    run_op("div_ovf",  MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 35, bn);
    run_op("mulu_5x1", MDU_MULU, 32'd5, 32'd1, 32'd0, 32'd5, 1'b0, mul_lat(32'd1), bn);
    run_op("mulu_5x0", MDU_MULU, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0, mul_lat(32'd0), bn);
    run_op("mul_min",  MDU_MUL,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 35, bn);
    run_op("mulu_x10", MDU_MULU, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, 1'b0, mul_lat(32'h10), bn);
    run_op("div_7n2",  MDU_DIV,  32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 35, bn);
    run_op("divu_one", MDU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 35, bn);
    run_op("div_n8n3", MDU_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2, 1'b0, 35, bn);

    // Flush during CALC cycle 10, with a stray start pulse while busy.
    issue(MDU_MULU, 32'd3, 32'h8000_0000, t0);
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    chk("flush_busy", 64'(busy_o), 64'(0));
    chk("flush_done", 64'(done_o), 64'(0));
    chk("flush_hi",   64'(hi_o), 64'hFFFF_FFFE);
    chk("flush_lo",   64'(lo_o), 64'd2);
    quiet = 0;
    repeat (50) begin
      @(posedge clk_i);
      #1;
      if (busy_o || done_o) quiet++;
    end
    chk("flush_quiet", 64'(quiet), 64'(0));

    // Asynchronous reset in the middle of CALC.
    issue(MDU_DIVU, 32'd1000, 32'd3, t0);
    repeat (10) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst_busy", 64'(busy_o), 64'(0));
    chk("arst_done", 64'(done_o), 64'(0));
    chk("arst_hi",   64'(hi_o),   64'(0));
    chk("arst_lo",   64'(lo_o),   64'(0));
    chk("arst_dz",   64'(div_zero_o), 64'(0));
    @(negedge clk_i);
    rst_i = 1'b1;

    run_op("mul_m1m1", MDU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, mul_lat(32'd1), bn);

    repeat (5) @(posedge clk_i);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit; the next-generation companion to the single-cycle ALU in the CPU datapath.
- Executes unsigned/signed multiply and unsigned/signed divide on DATA_W-bit operands, producing a 2*DATA_W-bit result split as hi/lo.
- Decoder/control issues ops via a start/busy/done handshake; results are written back through the register-file write mux.

Parameters:
- DATA_W, 32, operand width in bits; legal range 8..64, even.
- CNT_W, $clog2(DATA_W+1), iteration counter width (derived, not overridden).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request new op; sampled only in IDLE.
- mode_i  input  2  op select: MULU/MUL/DIVU/DIV (package constants).
- src1_i  input  DATA_W  multiplicand / dividend.
- src2_i  input  DATA_W  multiplier / divisor.
- flush_i  input  1  abort current op, return to IDLE.
- busy_o  output  1  op in progress (PREP..FIX).
- done_o  output  1  one-cycle pulse, results valid.
- hi_o  output  DATA_W  product[2W-1:W] / remainder.
- lo_o  output  DATA_W  product[W-1:0] / quotient.
- div_zero_o  output  1  last divide had src2_i==0; held with results.

Behaviour:
- Reset (rst_i low, async): state=IDLE; busy_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0; counter=0.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE: start_i=1 latches mode_i/src1_i/src2_i, goes to PREP. start_i outside IDLE is ignored (no queueing).
- PREP (1 cycle):
  - Signed modes: take the absolute value of each operand; record result sign (mul: s1^s2; div quotient: s1^s2, remainder: s1).
  - Divide with divisor 0: go straight to DONE with hi=src1 (raw), lo=all-ones, div_zero_o=1.
  - Otherwise: counter=DATA_W, go to CALC.
- CALC (DATA_W cycles, one bit per cycle):
  - Multiply: shift-add into a 2W accumulator.
  - Divide: restoring shift-subtract.
  - Counter decrements each cycle; at counter==1, go to FIX.
- FIX (1 cycle): apply two's-complement sign correction to the selected halves; go to DONE.
- DONE (1 cycle): done_o=1; hi_o/lo_o registered.
  - Outputs hold until the next op's DONE.
  - div_zero_o clears at the next accepted start.
- Latency:
  - Normal: done_o high in the cycle after the DATA_W+3rd rising edge following the start-sampling edge (35 for DATA_W=32).
  - Divide-by-zero: 2.
- busy_o is high from the edge after start acceptance until the DONE entry edge; low in IDLE and DONE.
- Back-to-back: start_i is legal only in IDLE. Earliest next start is sampled in the cycle after the done_o pulse.
- Signed overflow (DIV, MIN / -1): lo=MIN, hi=0, normal latency, no flag.
- flush_i (any state, synchronous):
  - Next state is IDLE; busy_o=0 and done_o=0 next cycle.
  - hi_o/lo_o/div_zero_o keep their previous values.
  - flush_i beats start_i when both are asserted in IDLE.
- Width rules:
  - Accumulator is 2*DATA_W bits; divider partial remainder is DATA_W+1 bits.
  - All sign fixes are done at full width.
  - No truncation except the defined hi/lo split.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: in multiply modes, CALC exits to FIX as soon as the remaining unprocessed multiplier bits are all zero. Latency becomes 3 + (index of highest set bit of |src2|) + 1. A multiplier of 0 skips CALC entirely (latency 3).
- Undefined: fixed latency as above for all multiplies; divide latency is unaffected either way.

Decomposition:
- Package mdu_pkg:
  - mode constants MDU_MULU=2'b00, MDU_MUL=2'b01, MDU_DIVU=2'b10, MDU_DIV=2'b11;
  - state encoding (IDLE, PREP, CALC, FIX, DONE);
  - helper function for two's-complement negate.
- One natural sub-module: mdu_div_step, a combinational single restoring-division step (partial remainder, quotient bit) reused by the CALC datapath.
- Control FSM and multiply accumulator stay in mul_div_unit.

Test Plan:
- MULU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done_o exactly 35 cycles after start, busy_o high for 34.
- MUL -7*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100/0 -> done at cycle 2, div_zero_o=1, lo=0xFFFFFFFF, hi=100; next accepted start clears div_zero_o.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero_o=0.
- start_i pulsed while busy and flush_i at CALC cycle 10 -> second start ignored; after flush, busy_o=0, no done_o, prior hi/lo unchanged; rst_i low mid-CALC -> all outputs 0 immediately.
- With MDU_EARLY_OUT_EN: MULU 5*1 -> lo=5, done at cycle 4; MULU 5*0 -> lo=0, done at cycle 3; without the macro both take 35.
